// File: rtl/seq_rotator.sv
// Multi-cycle rotate / logical shift / arithmetic shift engine.
// Moves the latched word up to STEP bit positions per clock under a start/busy/done handshake.
module seq_rotator #(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int AW   = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  in_seq,
    output logic [N-1:0]  out_seq,
    output logic          busy,
    output logic          done
);

    // Per-clock move width must be able to hold both STEP and any count value.
    localparam int SW = ($clog2(STEP + 1) > AW) ? $clog2(STEP + 1) : AW;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam logic [1:0] MODE_LSH = 2'b01;
    localparam logic [1:0] MODE_ASH = 2'b10;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic [1:0]    mode_q, mode_d;
    logic [N-1:0]  out_q, out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [SW-1:0] step_amt;
    logic [N-1:0]  asr_val;
    logic [N-1:0]  moved;

    always_comb begin
        if (SW'(cnt_q) < SW'(STEP)) begin
            step_amt = SW'(cnt_q);
        end else begin
            step_amt = SW'(STEP);
        end

        // Arithmetic right shift replicates the current sign bit into vacated positions.
        asr_val = $unsigned($signed(out_q) >>> step_amt);

        case (mode_q)
            MODE_LSH: moved = dir_q ? (out_q << step_amt) : (out_q >> step_amt);
            MODE_ASH: moved = dir_q ? (out_q << step_amt) : asr_val;
            default: begin
                if (dir_q) begin
                    moved = (out_q << step_amt) | (out_q >> (N - int'(step_amt)));
                end else begin
                    moved = (out_q >> step_amt) | (out_q << (N - int'(step_amt)));
                end
            end
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    out_d   = in_seq;
                    cnt_d   = amt;
                    dir_d   = dir;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    out_d = moved;
                    cnt_d = cnt_q - AW'(step_amt);
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_seq = out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
